// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg: shared constants and types for the four-bank word-interleaved
// memory responder (banked_mem_resp) and its per-bank occupancy timers.
package banked_mem_pkg;

  localparam int unsigned NUM_BANKS    = 4;
  localparam int unsigned BANK_CYCLES  = 4;  // cycles a bank is held per access
  localparam int unsigned RD_LAT       = 2;  // accept edge -> data_out cycle
  localparam int unsigned BANK_SEL_LSB = 1;  // bank = addr[2:1]
  localparam int unsigned BANK_SEL_MSB = 2;
  localparam int unsigned TIMER_W      = 2;

  typedef logic [BANK_SEL_MSB-BANK_SEL_LSB:0] bank_idx_t;
  typedef logic [TIMER_W-1:0]                 timer_t;

  // Loaded on accept; the bank reads busy for the remaining BANK_CYCLES-1 cycles.
  localparam timer_t TIMER_LOAD = timer_t'(BANK_CYCLES - 1);

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_READ,
    REQ_WRITE,
    REQ_ILLEGAL
  } req_kind_t;

  function automatic bank_idx_t bank_of(input logic [15:0] a);
    return a[BANK_SEL_MSB:BANK_SEL_LSB];
  endfunction

endpackage

// File: rtl/banked_mem_resp_bank_timer.sv
// bank_timer: occupancy timer for one memory bank.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous reset, active-low
//   load  - access accepted to this bank this cycle
//   busy  - bank occupied (counter non-zero)
module bank_timer
  import banked_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  timer_t cnt_q;
  timer_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TIMER_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - timer_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/banked_mem_resp.sv
// banked_mem_resp: four-bank, word-interleaved main-memory responder.
// One read or write is accepted per cycle when the addressed bank is idle; each
// access holds its bank for four cycles; read data appears on data_out exactly
// two cycles after acceptance (one cycle wide, zero otherwise).
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous reset, active-low
//   addr      - byte address; bank = addr[2:1], word = addr[ADDR_W:1]
//   data_in   - write data, sampled in the accept cycle
//   wr / rd   - write / read request
//   data_out  - read data (valid in T+2 for a read accepted in T, else 0)
//   stall     - request to a busy bank, not accepted
//   busy      - per-bank busy flags
//   err       - illegal request (rd & wr, or misaligned when checked)
// Configuration: define BANKED_MEM_ALIGN_CHK_EN to reject requests with addr[0] = 1.
module banked_mem_resp
  import banked_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          addr,
  input  logic [15:0]          data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [15:0]          data_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  logic [15:0]          mem_q [2**ADDR_W];
  logic [ADDR_W-1:0]    word;
  bank_idx_t            bank;
  req_kind_t            kind;
  logic                 accept;
  logic                 rd_acc;
  logic                 wr_acc;
  logic [NUM_BANKS-1:0] load;

  logic                 rd_vld_q;
  logic [15:0]          rd_data_q;
  logic [15:0]          dout_q;
  logic [15:0]          dout_d;

  // addr bits above the word index never select storage; addr[0] is only
  // inspected when alignment checking is built in.
  logic unused_addr;
  assign unused_addr = ^{addr[15:ADDR_W+1], addr[0]};

  assign word = addr[ADDR_W:1];
  assign bank = bank_of(addr);

  always_comb begin
    kind = REQ_NONE;
    if (rd && wr) begin
      kind = REQ_ILLEGAL;
    end else if (rd) begin
      kind = REQ_READ;
    end else if (wr) begin
      kind = REQ_WRITE;
    end
`ifdef BANKED_MEM_ALIGN_CHK_EN
    if ((rd || wr) && addr[0]) begin
      kind = REQ_ILLEGAL;
    end
`endif
  end

  always_comb begin
    err    = (kind == REQ_ILLEGAL);
    stall  = 1'b0;
    accept = 1'b0;
    if (kind == REQ_READ || kind == REQ_WRITE) begin
      stall  = busy[bank];
      accept = !busy[bank];
    end
    rd_acc = accept && (kind == REQ_READ);
    wr_acc = accept && (kind == REQ_WRITE);
  end

  always_comb begin
    load = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank == bank_idx_t'(b)) begin
        load[b] = accept;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    bank_timer u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (load[g]),
      .busy (busy[g])
    );
  end

  // Storage and the stage-1 data word carry no reset; stage-1 data is
  // qualified by rd_vld_q, which is reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[word] <= data_in;
    end
    if (rd_acc) begin
      rd_data_q <= mem_q[word];
    end
  end

  assign dout_d = rd_vld_q ? rd_data_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      rd_vld_q <= rd_acc;
      dout_q   <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_banked_mem_resp.sv
module tb_banked_mem_resp;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  banked_mem_resp #(.ADDR_W(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: data_out carries the queued word in its due cycle, zero otherwise.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_total++;
      $display("FAIL rd_missed @cyc %0d: read data %h due in cycle %0d never checked", cyc, e.data, e.cyc);
    end
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("rd_data", data_out, e.data);
    end else begin
      chk("idle_zero", data_out, 16'h0000);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd = 1'b0;
    wr = 1'b0;
    repeat (n) step();
  endtask

  // Drive one cycle of request, check the combinational decision, and, when the
  // read is expected to be accepted, queue its data for cycle T+2.
  task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic es, input logic ee, input logic [3:0] eb,
                     input logic push, input logic [15:0] ed);
    rd      = r;
    wr      = w;
    addr    = a;
    data_in = d;
    if (push) exp_q.push_back('{cyc + 2, ed});
    @(negedge clk);
    chk($sformatf("stall a=%h", a), {15'b0, stall}, {15'b0, es});
    chk($sformatf("err a=%h", a), {15'b0, err}, {15'b0, ee});
    chk($sformatf("busy a=%h", a), {12'b0, busy}, {12'b0, eb});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_busy", {12'b0, busy}, 16'h0000);
    chk("rst_dout", data_out, 16'h0000);
    rd = 1'b1;
    #1;
    chk("rst_stall", {15'b0, stall}, 16'h0000);
    chk("rst_err_rd", {15'b0, err}, 16'h0000);
    wr = 1'b1;
    #1;
    chk("rst_err_rdwr", {15'b0, err}, 16'h0001);
    rd = 1'b0; wr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Preload words 0..3 across banks 0..3, then read them back-to-back.
    req(0, 1, 16'h0000, 16'h0001, 0, 0, 4'b0000, 0, 16'h0);
    req(0, 1, 16'h0002, 16'h0002, 0, 0, 4'b0001, 0, 16'h0);
    req(0, 1, 16'h0004, 16'h0003, 0, 0, 4'b0011, 0, 16'h0);
    req(0, 1, 16'h0006, 16'h0004, 0, 0, 4'b0111, 0, 16'h0);
    req(1, 0, 16'h0000, 16'h0000, 0, 0, 4'b1110, 1, 16'h0001);
    req(1, 0, 16'h0002, 16'h0000, 0, 0, 4'b1101, 1, 16'h0002);
    req(1, 0, 16'h0004, 16'h0000, 0, 0, 4'b1011, 1, 16'h0003);
    req(1, 0, 16'h0006, 16'h0000, 0, 0, 4'b0111, 1, 16'h0004);
    idle(4);

    // Write then same-bank read exactly four cycles later.
    req(0, 1, 16'h0010, 16'hBEEF, 0, 0, 4'b0000, 0, 16'h0);
    idle(3);
    req(1, 0, 16'h0010, 16'h0000, 0, 0, 4'b0000, 1, 16'hBEEF);
    idle(3);
    req(0, 1, 16'h0008, 16'h0055, 0, 0, 4'b0000, 0, 16'h0);
    idle(3);

    // Same-bank conflict: stalled three cycles, accepted on the fourth.
    req(1, 0, 16'h0008, 16'h0000, 0, 0, 4'b0000, 1, 16'h0055);
    req(1, 0, 16'h0000, 16'h0000, 1, 0, 4'b0001, 0, 16'h0);
    req(1, 0, 16'h0000, 16'h0000, 1, 0, 4'b0001, 0, 16'h0);
    req(1, 0, 16'h0000, 16'h0000, 1, 0, 4'b0001, 0, 16'h0);
    req(1, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 1, 16'h0001);
    idle(4);

    // rd & wr together: err, no stall, no timer load, no write.
    req(1, 0, 16'h0004, 16'h0000, 0, 0, 4'b0000, 1, 16'h0003);
    req(1, 1, 16'h0004, 16'hDEAD, 0, 1, 4'b0100, 0, 16'h0);
    req(1, 1, 16'h0002, 16'hDEAD, 0, 1, 4'b0100, 0, 16'h0);
    req(1, 0, 16'h0002, 16'h0000, 0, 0, 4'b0100, 1, 16'h0002);
    req(1, 0, 16'h0004, 16'h0000, 0, 0, 4'b0010, 1, 16'h0003);
    idle(4);

    // Misaligned read of 0x0003 (word 1, bank 1).
`ifdef BANKED_MEM_ALIGN_CHK_EN
    req(1, 0, 16'h0003, 16'h0000, 0, 1, 4'b0000, 0, 16'h0);
    req(1, 0, 16'h0008, 16'h0000, 0, 0, 4'b0000, 1, 16'h0055);
`else
    req(1, 0, 16'h0003, 16'h0000, 0, 0, 4'b0000, 1, 16'h0002);
    req(1, 0, 16'h0008, 16'h0000, 0, 0, 4'b0010, 1, 16'h0055);
`endif
    idle(4);

    // Reset while a read is in flight: discarded, storage survives.
    req(1, 0, 16'h0006, 16'h0000, 0, 0, 4'b0000, 0, 16'h0);
    rd = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_busy", {12'b0, busy}, 16'h0000);
    chk("midrst_dout", data_out, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(6);
    req(1, 0, 16'h0010, 16'h0000, 0, 0, 4'b0000, 1, 16'hBEEF);
    req(1, 0, 16'h0002, 16'h0000, 0, 0, 4'b0001, 1, 16'h0002);
    idle(4);

    chk("drain", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
